// File: rtl/fifo_rr_arb.sv
// fifo_rr_arb: round-robin arbiter that drains up to BURST words per grant from
// NQ external sync FIFOs into one registered ready/valid output slot.
module fifo_rr_arb #(
    parameter int unsigned WID   = 32,
    parameter int unsigned NQ    = 4,
    parameter int unsigned BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              softreset,
    input  logic [NQ-1:0]     enable,
    input  logic [NQ-1:0]     empty,
    input  logic [NQ*WID-1:0] fifo_dout,
    output logic [NQ-1:0]     readout,
    output logic [NQ-1:0]     grant,
    output logic              vldout,
    output logic [WID-1:0]    dout,
    input  logic              ready
);
    localparam int unsigned     IDXW     = (NQ > 1) ? $clog2(NQ) : 1;
    localparam int unsigned     CNTW     = 8;
    localparam logic [CNTW-1:0] BURST_C  = CNTW'(BURST);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NQ - 1);

    typedef enum logic {
        S_IDLE,
        S_SERVE
    } state_e;

    state_e          state_q, state_d;
    logic [NQ-1:0]   grant_q, grant_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [CNTW-1:0] burst_q, burst_d;
    logic            vld_q, vld_d;
    logic [WID-1:0]  dout_q, dout_d;

    logic [WID-1:0]  head [NQ];
    logic [NQ-1:0]   eligible;
    logic            slot_free;
    logic            pop;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic [IDXW-1:0] cand;
    logic [CNTW-1:0] burst_inc;

    for (genvar i = 0; i < NQ; i++) begin : g_head
        assign head[i] = fifo_dout[i*WID +: WID];
    end

    assign eligible  = enable & ~empty;
    assign slot_free = !vld_q || ready;
    assign pop       = (state_q == S_SERVE) && slot_free && !empty[last_q]
                       && enable[last_q] && !softreset;
    assign burst_inc = (burst_q == '1) ? burst_q : burst_q + CNTW'(1);

    // First eligible queue strictly after the last owner, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_q;
        cand       = '0;
        for (int unsigned k = 1; k <= NQ; k++) begin
            cand = IDXW'((32'(last_q) + k) % NQ);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        vld_d   = vld_q;
        dout_d  = dout_q;
        readout = '0;

        // Output slot: a pop refills it, an accept without a pop empties it.
        if (pop) begin
            readout[last_q] = 1'b1;
            dout_d          = head[last_q];
            vld_d           = 1'b1;
        end else if (ready) begin
            vld_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d           = S_SERVE;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    last_d            = pick_idx;
                    burst_d           = '0;
                end
            end
            S_SERVE: begin
                if (pop) begin
                    burst_d = burst_inc;
                end
                if ((pop && burst_inc == BURST_C) || (!pop && empty[last_q])
                    || !enable[last_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        if (softreset) begin
            state_d = S_IDLE;
            grant_d = '0;
            last_d  = LAST_RST;
            burst_d = '0;
            vld_d   = 1'b0;
            dout_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            burst_q <= '0;
            vld_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            vld_q   <= vld_d;
            dout_q  <= dout_d;
        end
    end

    assign grant  = grant_q;
    assign vldout = vld_q;
    assign dout   = dout_q;

endmodule

// File: doc/fifo_rr_arb.md
FIFO_RR_ARB -- requirements
Module: fifo_rr_arb

Interface
REQ-001 The module SHALL have parameter WID, default 32, as the data width of each queue and of the output.
REQ-002 The module SHALL have parameter NQ, default 4, as the number of syncfifo queues arbitrated (2..16).
REQ-003 The module SHALL have parameter BURST, default 4, as the maximum consecutive pops per grant (1..255).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port softreset, input, 1 bit: synchronous clear, same effect as rst_n.
REQ-007 The module SHALL have port enable, input, NQ bits: per-queue eligibility mask.
REQ-008 The module SHALL have port empty, input, NQ bits: empty flag of each queue.
REQ-009 The module SHALL have port fifo_dout, input, NQ*WID bits: head data; queue i occupies bits [i*WID+WID-1 : i*WID].
REQ-010 The module SHALL have port readout, output, NQ bits: one-hot pop strobe to the queues.
REQ-011 The module SHALL have port grant, output, NQ bits: one-hot current owner; all zero when idle.
REQ-012 The module SHALL have port vldout, output, 1 bit: dout holds a valid word.
REQ-013 The module SHALL have port dout, output, WID bits: registered output word.
REQ-014 The module SHALL have port ready, input, 1 bit: downstream accepts dout this cycle when vldout=1.

Function
REQ-015 State machine: IDLE (arbitrate) and SERVE (drain the granted queue); at most one queue granted at any time.
REQ-016 In IDLE, with eligible = enable & ~empty nonzero, the module SHALL select the first eligible index after last (wrapping NQ-1 -> 0), set grant, load last with that index, clear burst counter, and go to SERVE next cycle.
REQ-017 In IDLE with eligible zero, the module SHALL remain in IDLE with grant zero.
REQ-018 slot_free = !vldout || ready.
REQ-019 In SERVE, readout[g] SHALL be combinationally 1 iff slot_free && !empty[g] && enable[g]; all other readout bits SHALL be 0; readout SHALL be all zero outside SERVE.
REQ-020 On a cycle with readout[g]=1, the module SHALL register slice g of fifo_dout into dout, set vldout=1 next cycle, and increment the burst counter (latency pop -> vldout: 1 cycle).
REQ-021 When vldout=1 and ready=0, dout and vldout SHALL hold unchanged.
REQ-022 When vldout=1, ready=1, and no pop occurs, vldout SHALL clear next cycle.
REQ-023 Same-cycle accept and pop SHALL replace dout with no bubble.
REQ-024 SERVE SHALL exit to IDLE (grant cleared next cycle) when the pop that makes burst counter = BURST occurs, when empty[g]=1 with no pop, or when enable[g]=0.
REQ-025 One IDLE cycle SHALL occur between consecutive grants; a queue emptied mid-burst SHALL forfeit the rest of its burst.
REQ-026 The burst counter SHALL be 8 bits, SHALL not wrap, and SHALL be reset on every new grant.
REQ-027 Data SHALL never be dropped or duplicated: each readout pulse SHALL correspond to exactly one vldout&&ready transfer.

Reset
REQ-028 On rst_n=0 (asynchronous) or softreset=1 (synchronous, highest priority over all other activity), the module SHALL go to IDLE with grant=0, vldout=0, dout=0, burst counter=0, last=NQ-1 so queue 0 wins first, and readout=0 immediately.
REQ-029 Reset mid-burst SHALL discard the held dout word; queue contents are the queues' responsibility.

Verification
REQ-030 Scenario: reset, queues 0..3 each hold 2 words, enable=4'hF, ready=1 -> outputs q0w0,q0w1,q1w0,q1w1,q2..,q3.., each grant separated by one IDLE cycle.
REQ-031 Scenario: BURST=4, q1 holds 10 words, q2 holds 10 words, ready=1 -> pattern q1x4,q2x4,q1x4,q2x4,q1x2,q2x2.
REQ-032 Scenario: ready held 0 for 5 cycles while vldout=1 -> dout stable, readout=0 throughout, then exactly one pop per accepting cycle.
REQ-033 Scenario: enable=4'b0100 with all queues non-empty -> only q2 popped; q0/q1/q3 readout never asserted.
REQ-034 Scenario: softreset pulsed mid-burst on q3 -> next cycle vldout=0, grant=0; next grant goes to q0 if eligible.
REQ-035 Scenario: q0 holds 1 word, BURST=4 -> single pop, exit on empty, grant=0 two cycles after grant.
